// File: rtl/dispatch_2_infill.sv
// Round-robin 1-to-2 stream dispatcher with a 2-entry buffer on each output.
// Downstream almost_full gates new dispatch; buffered beats keep draining.

module dispatch_2_infill_buf #(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              ready,
    output logic [DWIDTH-1:0] data,
    output logic              valid,
    output logic              full
);

    logic [DWIDTH-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              pop;

    assign pop   = valid && ready;
    assign valid = (count != 2'd0);
    assign full  = (count == 2'd2);
    assign data  = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            // NOTE: the two storage words are reset too, because out_data must read 0
            // after reset; larger memories would normally be left unreset.
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

module dispatch_2_infill #(
    parameter int DWIDTH = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DWIDTH-1:0] out_data_0,
    output logic              out_valid_0,
    input  logic              out_ready_0,
    input  logic              out_almost_full_0,
    output logic [DWIDTH-1:0] out_data_1,
    output logic              out_valid_1,
    input  logic              out_ready_1,
    input  logic              out_almost_full_1,
    output logic [CNT_W-1:0]  cnt_0,
    output logic [CNT_W-1:0]  cnt_1,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic full_0;
    logic full_1;
    logic elig_0;
    logic elig_1;
    logic sel;
    logic last;
    logic accept;
    logic push_0;
    logic push_1;

    // Eligibility uses registered occupancy only, so out_ready never reaches in_ready.
    assign elig_0   = !full_0 && !out_almost_full_0;
    assign elig_1   = !full_1 && !out_almost_full_1;
    assign in_ready = (elig_0 || elig_1) && !rst;
    assign accept   = in_valid && in_ready;

    // NOTE: always_comb assigns a default first so no path leaves sel unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        sel = 1'b0;
        if (elig_0 && elig_1) begin
            sel = ~last;
        end else if (elig_1) begin
            sel = 1'b1;
        end
    end

    assign push_0 = accept && !sel;
    assign push_1 = accept && sel;

    dispatch_2_infill_buf #(.DWIDTH(DWIDTH)) u_buf_0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push_0),
        .push_data (in_data),
        .ready     (out_ready_0),
        .data      (out_data_0),
        .valid     (out_valid_0),
        .full      (full_0)
    );

    dispatch_2_infill_buf #(.DWIDTH(DWIDTH)) u_buf_1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push_1),
        .push_data (in_data),
        .ready     (out_ready_1),
        .data      (out_data_1),
        .valid     (out_valid_1),
        .full      (full_1)
    );

    // last starts at 1 so the first dispatch after reset goes to output 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= 1'b1;
            cnt_0     <= '0;
            cnt_1     <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept) begin
                last <= sel;
            end
            if (push_0) begin
                cnt_0 <= cnt_0 + CNT_ONE;
            end
            if (push_1) begin
                cnt_1 <= cnt_1 + CNT_ONE;
            end
            if (in_valid && !in_ready) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end

endmodule
